// File: rtl/mem_lsu_bus.sv
// Load/store unit bus front end: decodes memory ops, runs one big-endian bus transfer
// at a time with an abort timer, and registers the writeback result and exception flags.
module mem_lsu_bus #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [3:0]        op_i,
    input  logic [31:0]       addr_i,
    input  logic [DW-1:0]     sdata_i,
    input  logic [DW-1:0]     res_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DW-1:0]     wdata_o,
    output logic              misalign_o,
    output logic              buserr_o,
    output logic [31:0]       badaddr_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [31:0]       bus_addr_o,
    output logic [DW/8-1:0]   bus_sel_o,
    output logic [DW-1:0]     bus_wdata_o,
    input  logic [DW-1:0]     bus_rdata_i,
    input  logic              bus_ack_i
);
    localparam int LANES = DW / 8;
    localparam int LB = $clog2(LANES);
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    // state | meaning
    // IDLE  | accepting instructions, no bus transfer outstanding
    // BUS   | request held on the bus, waiting for ack or timeout
    typedef enum logic {IDLE, BUS} state_t;
    state_t state, state_nx;

    logic          is_ld, is_st, sgn;
    logic [3:0]    nbytes;
    logic          misal, accept, go_bus, finish;
    logic [LB-1:0] lane_in, lane_q;
    logic [LANES-1:0] sel_nx;
    logic [DW-1:0] wdat_nx, rd_sh, ld_val;
    logic [6:0]    shamt;
    logic [9:0]    cnt;
    logic          kill;
    logic [31:0]   addr_q;
    logic [4:0]    wd_q;
    logic          wreg_q, ld_q, sgn_q;
    logic [3:0]    nb_q;

    always_comb begin
        is_ld = 1'b0;
        is_st = 1'b0;
        sgn = 1'b0;
        nbytes = 4'd0;
        case (op_i)
            4'd1:  begin is_ld = 1'b1; sgn = 1'b1; nbytes = 4'd1; end
            4'd2:  begin is_ld = 1'b1; nbytes = 4'd1; end
            4'd3:  begin is_ld = 1'b1; sgn = 1'b1; nbytes = 4'd2; end
            4'd4:  begin is_ld = 1'b1; nbytes = 4'd2; end
            4'd5:  begin is_ld = 1'b1; sgn = 1'b1; nbytes = 4'd4; end
            4'd6:  if (DW == 64) begin is_ld = 1'b1; nbytes = 4'd4; end
            4'd7:  if (DW == 64) begin is_ld = 1'b1; nbytes = 4'd8; end
            4'd9:  begin is_st = 1'b1; nbytes = 4'd1; end
            4'd10: begin is_st = 1'b1; nbytes = 4'd2; end
            4'd11: begin is_st = 1'b1; nbytes = 4'd4; end
            4'd12: if (DW == 64) begin is_st = 1'b1; nbytes = 4'd8; end
            default: ;
        endcase
    end

    assign misal = (nbytes == 4'd2 && addr_i[0]) ||
                   (nbytes == 4'd4 && addr_i[1:0] != 2'd0) ||
                   (nbytes == 4'd8 && addr_i[2:0] != 3'd0);
    assign accept  = (state == IDLE) && valid_i && !flush_i;
    assign go_bus  = accept && (is_ld || is_st) && !misal;
    assign finish  = bus_ack_i || (cnt == TO_LAST);
    assign lane_in = addr_i[LB-1:0];

    // Lane 0 (lowest address) drives the MSB of the select vector.
    always_comb begin
        sel_nx = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i >= int'(lane_in) && i < int'(lane_in) + int'(nbytes))
                sel_nx[LANES-1-i] = 1'b1;
        end
    end

    always_comb begin
        case (nbytes)
            4'd1:    wdat_nx = {LANES{sdata_i[7:0]}};
            4'd2:    wdat_nx = {(LANES/2){sdata_i[15:0]}};
            4'd4:    wdat_nx = {(LANES/4){sdata_i[31:0]}};
            default: wdat_nx = sdata_i;
        endcase
    end

    // Shift the addressed lane to the top, then bring it down with the right extension.
    assign lane_q = addr_q[LB-1:0];
    assign rd_sh  = bus_rdata_i << {lane_q, 3'b000};
    assign shamt  = 7'(DW) - {nb_q, 3'b000};
    always_comb begin
        if (sgn_q) ld_val = $signed(rd_sh) >>> shamt;
        else       ld_val = rd_sh >> shamt;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall_o = 1'b0;
        case (state)
            IDLE: if (go_bus) begin
                state_nx = BUS;
                stall_o = 1'b1;
            end
            BUS: if (finish) state_nx = IDLE;
                 else        stall_o = 1'b1;
            default: state_nx = IDLE;
        endcase
        if (rst) stall_o = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0; kill <= 1'b0;
            bus_req_o <= 1'b0; bus_we_o <= 1'b0; bus_sel_o <= '0;
            bus_addr_o <= '0; bus_wdata_o <= '0;
            valid_o <= 1'b0; wreg_o <= 1'b0; wd_o <= '0; wdata_o <= '0;
            misalign_o <= 1'b0; buserr_o <= 1'b0; badaddr_o <= '0;
            addr_q <= '0; wd_q <= '0; wreg_q <= 1'b0;
            ld_q <= 1'b0; sgn_q <= 1'b0; nb_q <= '0;
        end else begin
            valid_o <= 1'b0;
            wreg_o <= 1'b0;
            misalign_o <= 1'b0;
            buserr_o <= 1'b0;
            if (state == IDLE) begin
                if (accept && !(is_ld || is_st)) begin
                    valid_o <= 1'b1;
                    wdata_o <= res_i;
                    wd_o <= wd_i;
                    wreg_o <= wreg_i;
                end else if (accept && misal) begin
                    valid_o <= 1'b1;
                    misalign_o <= 1'b1;
                    badaddr_o <= addr_i;
                    wd_o <= wd_i;
                end else if (go_bus) begin
                    bus_req_o <= 1'b1;
                    bus_we_o <= is_st;
                    bus_addr_o <= {addr_i[31:LB], {LB{1'b0}}};
                    bus_sel_o <= sel_nx;
                    bus_wdata_o <= is_st ? wdat_nx : '0;
                    addr_q <= addr_i;
                    wd_q <= wd_i;
                    wreg_q <= wreg_i & is_ld;
                    ld_q <= is_ld;
                    sgn_q <= sgn;
                    nb_q <= nbytes;
                    cnt <= '0;
                    kill <= 1'b0;
                end
            end else begin
                if (flush_i) kill <= 1'b1;
                if (finish) begin
                    bus_req_o <= 1'b0;
                    bus_we_o <= 1'b0;
                    cnt <= '0;
                    kill <= 1'b0;
                    // A flush landing in the completion cycle still kills the result.
                    if (!(kill || flush_i)) begin
                        valid_o <= 1'b1;
                        wd_o <= wd_q;
                        if (bus_ack_i) begin
                            wreg_o <= wreg_q;
                            if (ld_q) wdata_o <= ld_val;
                        end else begin
                            buserr_o <= 1'b1;
                            badaddr_o <= addr_q;
                        end
                    end
                end else begin
                    cnt <= cnt + 10'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_lsu_bus.sv
// Bench for mem_lsu_bus: a DW=32/TIMEOUT=4 and a DW=64/TIMEOUT=6 instance share one
// stimulus set (gated by use_b) and are checked against a byte-level reference model.
module tb_mem_lsu_bus;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid, flush, wreg, ack, use_b;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [63:0] sdata, res, rdata;
    logic [4:0]  wd;

    logic        a_stall, a_valid, a_wreg, a_mis, a_berr, a_req, a_we;
    logic [4:0]  a_wd;
    logic [31:0] a_wdata, a_bad, a_baddr, a_bwdata;
    logic [3:0]  a_sel;
    logic        b_stall, b_valid, b_wreg, b_mis, b_berr, b_req, b_we;
    logic [4:0]  b_wd;
    logic [63:0] b_wdata, b_bwdata;
    logic [31:0] b_bad, b_baddr;
    logic [7:0]  b_sel;

    mem_lsu_bus #(.DW(32), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst), .valid_i(valid & ~use_b), .op_i(op), .addr_i(addr),
        .sdata_i(sdata[31:0]), .res_i(res[31:0]), .wd_i(wd), .wreg_i(wreg), .flush_i(flush),
        .stall_o(a_stall), .valid_o(a_valid), .wd_o(a_wd), .wreg_o(a_wreg), .wdata_o(a_wdata),
        .misalign_o(a_mis), .buserr_o(a_berr), .badaddr_o(a_bad), .bus_req_o(a_req),
        .bus_we_o(a_we), .bus_addr_o(a_baddr), .bus_sel_o(a_sel), .bus_wdata_o(a_bwdata),
        .bus_rdata_i(rdata[31:0]), .bus_ack_i(ack & ~use_b));

    mem_lsu_bus #(.DW(64), .TIMEOUT(6)) dut_b (
        .clk(clk), .rst(rst), .valid_i(valid & use_b), .op_i(op), .addr_i(addr),
        .sdata_i(sdata), .res_i(res), .wd_i(wd), .wreg_i(wreg), .flush_i(flush),
        .stall_o(b_stall), .valid_o(b_valid), .wd_o(b_wd), .wreg_o(b_wreg), .wdata_o(b_wdata),
        .misalign_o(b_mis), .buserr_o(b_berr), .badaddr_o(b_bad), .bus_req_o(b_req),
        .bus_we_o(b_we), .bus_addr_o(b_baddr), .bus_sel_o(b_sel), .bus_wdata_o(b_bwdata),
        .bus_rdata_i(rdata), .bus_ack_i(ack & use_b));

    wire        o_stall = use_b ? b_stall : a_stall;
    wire        o_valid = use_b ? b_valid : a_valid;
    wire        o_wreg  = use_b ? b_wreg  : a_wreg;
    wire        o_mis   = use_b ? b_mis   : a_mis;
    wire        o_berr  = use_b ? b_berr  : a_berr;
    wire        o_req   = use_b ? b_req   : a_req;
    wire        o_we    = use_b ? b_we    : a_we;
    wire [4:0]  o_wd    = use_b ? b_wd    : a_wd;
    wire [63:0] o_wdata = use_b ? b_wdata : {32'd0, a_wdata};
    wire [63:0] o_bwd   = use_b ? b_bwdata : {32'd0, a_bwdata};
    wire [31:0] o_bad   = use_b ? b_bad   : a_bad;
    wire [31:0] o_baddr = use_b ? b_baddr : a_baddr;
    wire [7:0]  o_sel   = use_b ? b_sel   : {4'd0, a_sel};

    int errors = 0;
    int checks = 0;

    // Access size in bytes; 0 means the code behaves as NONE for this width.
    function automatic int op_bytes(input int dw, input logic [3:0] o);
        case (o)
            4'd1, 4'd2, 4'd9:  return 1;
            4'd3, 4'd4, 4'd10: return 2;
            4'd5, 4'd11:       return 4;
            4'd6:              return (dw == 64) ? 4 : 0;
            4'd7, 4'd12:       return (dw == 64) ? 8 : 0;
            default:           return 0;
        endcase
    endfunction

    function automatic logic [7:0] lane_byte(input int dw, input logic [63:0] d, input int j);
        logic [63:0] t;
        t = d >> (dw - 8 - 8 * j);
        return t[7:0];
    endfunction

    function automatic logic [7:0] exp_sel(input int dw, input int nb, input logic [31:0] a);
        logic [7:0] s;
        int lanes, k;
        lanes = dw / 8;
        k = int'(a % lanes);
        s = '0;
        for (int j = k; j < k + nb; j++) s[lanes-1-j] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] exp_wdata(input int dw, input int nb, input logic [63:0] d);
        logic [63:0] v, b;
        v = '0;
        for (int j = 0; j < dw / 8; j++) begin
            b = (d >> (8 * (nb - 1 - (j % nb)))) & 64'hFF;
            v = v | (b << (dw - 8 - 8 * j));
        end
        return v;
    endfunction

    function automatic logic [63:0] exp_load(input int dw, input logic [3:0] o,
                                             input logic [31:0] a, input logic [63:0] d);
        logic [63:0] v;
        int nb, k;
        nb = op_bytes(dw, o);
        k = int'(a % (dw / 8));
        v = '0;
        for (int j = 0; j < nb; j++) v = (v << 8) | 64'(lane_byte(dw, d, k + j));
        if ((o == 4'd1 || o == 4'd3 || o == 4'd5) && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
        if (dw == 32) v[63:32] = '0;
        return v;
    endfunction

    // One instruction end to end. ack_at/flush_at are BUS cycle numbers (1-based), 0 = never.
    task automatic txn(input logic [3:0] op_, input logic [31:0] addr_, input logic [63:0] sdata_,
                       input logic [63:0] rdata_, input int ack_at, input int flush_at);
        int dw, to, nb, c;
        bit st, mis, busop, done, killed, timed, exp_stall;
        logic [63:0] r, mask;
        logic [4:0] w;
        logic wr;
        dw = use_b ? 64 : 32;
        to = use_b ? 6 : 4;
        mask = use_b ? ~64'd0 : 64'hFFFF_FFFF;
        nb = op_bytes(dw, op_);
        st = (nb > 0) && (op_ >= 4'd9);
        mis = (nb > 0) && ((addr_ % nb) != 0);
        busop = (nb > 0) && !mis;
        r = {$urandom, $urandom};
        w = 5'($urandom);
        wr = 1'($urandom);
        @(negedge clk);
        valid = 1'b1; op = op_; addr = addr_; sdata = sdata_; rdata = rdata_;
        res = r; wd = w; wreg = wr; flush = 1'b0; ack = 1'b0;
        #1;
        checks++; if (o_stall !== busop) begin errors++; $display("FAIL accept_stall op=%0d: got %b want %b", op_, o_stall, busop); end
        @(negedge clk);
        if (!busop) begin
            valid = 1'b0;
            checks++; if (o_valid !== 1'b1 || o_mis !== mis || o_berr !== 1'b0 || o_req !== 1'b0)
                begin errors++; $display("FAIL nonbus_flags op=%0d: got v=%b m=%b e=%b req=%b want v=1 m=%b e=0 req=0", op_, o_valid, o_mis, o_berr, o_req, mis); end
            if (mis) begin
                checks++; if (o_bad !== addr_ || o_wreg !== 1'b0) begin errors++; $display("FAIL misalign op=%0d: got bad=%h wreg=%b want bad=%h wreg=0", op_, o_bad, o_wreg, addr_); end
            end else begin
                checks++; if (o_wdata !== (r & mask) || o_wd !== w || o_wreg !== wr)
                    begin errors++; $display("FAIL none_pass: got %h/%0d/%b want %h/%0d/%b", o_wdata, o_wd, o_wreg, r & mask, w, wr); end
            end
        end else begin
            checks++; if (o_req !== 1'b1 || o_we !== st || o_baddr !== (addr_ & ~32'(dw / 8 - 1)) || o_sel !== exp_sel(dw, nb, addr_))
                begin errors++; $display("FAIL bus_issue op=%0d: got req=%b we=%b addr=%h sel=%b want 1 %b %h %b", op_, o_req, o_we, o_baddr, o_sel, st, addr_ & ~32'(dw / 8 - 1), exp_sel(dw, nb, addr_)); end
            if (st) begin
                checks++; if (o_bwd !== exp_wdata(dw, nb, sdata_)) begin errors++; $display("FAIL store_data: got %h want %h", o_bwd, exp_wdata(dw, nb, sdata_)); end
            end
            done = 0; killed = 0; timed = 0; c = 1;
            while (!done) begin
                if (c == flush_at) begin flush = 1'b1; killed = 1; end
                if (c == ack_at) ack = 1'b1;
                done = (c == ack_at) || (c == to);
                timed = (c != ack_at) && (c == to);
                exp_stall = !done;
                #1;
                checks++; if (o_req !== 1'b1 || o_stall !== exp_stall) begin errors++; $display("FAIL bus_wait c=%0d: got req=%b stall=%b want req=1 stall=%b", c, o_req, o_stall, exp_stall); end
                @(negedge clk);
                flush = 1'b0; ack = 1'b0; c++;
            end
            valid = 1'b0;
            checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL bus_release: got req=%b want 0", o_req); end
            if (killed) begin
                checks++; if (o_valid !== 1'b0 || o_berr !== 1'b0 || o_wreg !== 1'b0 || o_mis !== 1'b0)
                    begin errors++; $display("FAIL killed: got v=%b e=%b wreg=%b m=%b want all 0", o_valid, o_berr, o_wreg, o_mis); end
            end else if (timed) begin
                checks++; if (o_valid !== 1'b1 || o_berr !== 1'b1 || o_bad !== addr_ || o_wreg !== 1'b0)
                    begin errors++; $display("FAIL timeout: got v=%b e=%b bad=%h wreg=%b want 1 1 %h 0", o_valid, o_berr, o_bad, o_wreg, addr_); end
            end else if (st) begin
                checks++; if (o_valid !== 1'b1 || o_wreg !== 1'b0 || o_berr !== 1'b0) begin errors++; $display("FAIL store_done: got v=%b wreg=%b e=%b want 1 0 0", o_valid, o_wreg, o_berr); end
            end else begin
                checks++; if (o_valid !== 1'b1 || o_wreg !== wr || o_wd !== w || o_berr !== 1'b0 || o_wdata !== exp_load(dw, op_, addr_, rdata_))
                    begin errors++; $display("FAIL load op=%0d addr=%h: got v=%b wreg=%b wd=%0d data=%h want 1 %b %0d %h", op_, addr_, o_valid, o_wreg, o_wd, o_wdata, wr, w, exp_load(dw, op_, addr_, rdata_)); end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; valid = 1'b1; op = 4'd5; addr = 32'h40;
        #1;
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", o_stall); end
        @(negedge clk);
        checks++; if ({a_valid, a_wreg, a_mis, a_berr, a_req, a_we} !== 6'd0 || a_wd !== 5'd0 || a_wdata !== 32'd0 ||
                      a_bad !== 32'd0 || a_baddr !== 32'd0 || a_sel !== 4'd0 || a_bwdata !== 32'd0)
            begin errors++; $display("FAIL reset_outputs_a: got v=%b req=%b sel=%b addr=%h", a_valid, a_req, a_sel, a_baddr); end
        checks++; if ({b_valid, b_wreg, b_mis, b_berr, b_req, b_we} !== 6'd0 || b_wdata !== 64'd0 || b_sel !== 8'd0 || b_bwdata !== 64'd0)
            begin errors++; $display("FAIL reset_outputs_b: got v=%b req=%b sel=%b", b_valid, b_req, b_sel); end
        rst = 1'b0; valid = 1'b0;
    endtask

    task automatic test_directed();
        use_b = 1'b0;
        txn(4'd1, 32'h101, '0, 64'h1280FF34, 2, 0);
        txn(4'd10, 32'h202, 64'h0000ABCD, '0, 1, 0);
        txn(4'd5, 32'h3, '0, '0, 1, 0);
        txn(4'd0, 32'h0, '0, '0, 1, 0);
        txn(4'd7, 32'h8, '0, '0, 1, 0);
        txn(4'd4, 32'h102, '0, 64'h1280FF34, 1, 0);
    endtask

    task automatic test_timeout();
        use_b = 1'b0;
        txn(4'd5, 32'h10, '0, 64'hDEADBEEF, 0, 0);
        @(negedge clk);
        ack = 1'b1;
        #1;
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL late_ack_stall: got %b want 0", o_stall); end
        @(negedge clk);
        ack = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_req !== 1'b0 || o_berr !== 1'b0) begin errors++; $display("FAIL late_ack: got v=%b req=%b e=%b want 0 0 0", o_valid, o_req, o_berr); end
    endtask

    task automatic test_flush();
        use_b = 1'b0;
        @(negedge clk);
        valid = 1'b1; op = 4'd5; addr = 32'h20; flush = 1'b1;
        #1;
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b want 0", o_stall); end
        @(negedge clk);
        valid = 1'b0; flush = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_req !== 1'b0) begin errors++; $display("FAIL flush_idle: got v=%b req=%b want 0 0", o_valid, o_req); end
        txn(4'd5, 32'h24, '0, 64'h11223344, 3, 1);
        txn(4'd9, 32'h25, 64'h5A, '0, 0, 2);
    endtask

    task automatic test_reset_mid_bus();
        use_b = 1'b0;
        @(negedge clk);
        valid = 1'b1; op = 4'd5; addr = 32'h30;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL midbus_reset_stall: got %b want 0", o_stall); end
        @(negedge clk);
        checks++; if (o_req !== 1'b0 || o_valid !== 1'b0 || o_sel !== 8'd0 || o_baddr !== 32'd0)
            begin errors++; $display("FAIL midbus_reset: got req=%b v=%b sel=%b addr=%h want 0", o_req, o_valid, o_sel, o_baddr); end
        rst = 1'b0; valid = 1'b0;
        txn(4'd5, 32'h34, '0, 64'hCAFEF00D, 1, 0);
    endtask

    task automatic test_dw64();
        use_b = 1'b1;
        txn(4'd7, 32'h8, '0, 64'h0123456789ABCDEF, 1, 0);
        checks++; if (o_wdata !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL ld64: got %h want 0123456789abcdef", o_wdata); end
        txn(4'd6, 32'hC, '0, 64'h0123456789ABCDEF, 2, 0);
        checks++; if (o_wdata !== 64'h0000000089ABCDEF) begin errors++; $display("FAIL lwu64: got %h want 0000000089abcdef", o_wdata); end
        txn(4'd12, 32'h10, 64'hFEDCBA9876543210, '0, 1, 0);
        txn(4'd5, 32'h24, '0, 64'h00000000F0000000, 0, 0);
    endtask

    task automatic test_random(input bit b);
        int to;
        use_b = b;
        to = b ? 6 : 4;
        for (int n = 0; n < 40; n++) begin
            txn(4'($urandom), $urandom & 32'h1FF, {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(1, to + 1), ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid = 1'b0; flush = 1'b0; ack = 1'b0; use_b = 1'b0;
        op = '0; addr = '0; sdata = '0; res = '0; rdata = '0; wd = '0; wreg = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_directed();
        test_timeout();
        test_flush();
        test_reset_mid_bus();
        test_dw64();
        test_random(1'b0);
        test_random(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
